// File: rtl/gfx_fill.sv
// Pixel write sequencer for the graphics RAM write port: CPU-programmed single-pixel
// writes and rectangular solid fills, one 4-bit pixel per clock.
module gfx_fill #(
    parameter int ADDR_W = 18,
    parameter int STRIDE = 640
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              cs_i,
    input  logic [2:0]        addr_i,
    input  logic [7:0]        din_i,
    input  logic              we_i,
    output logic [7:0]        dout_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] gw_o,
    output logic [3:0]        go_o,
    output logic              gwe_o
);

    typedef enum logic {
        S_IDLE,
        S_FILL
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] gw_q, gw_d;
    logic [9:0]        len_q, len_d;
    logic [9:0]        col_q, col_d;
    logic [8:0]        rows_q, rows_d;
    logic [8:0]        row_q, row_d;
    logic [3:0]        color_q, color_d;
    logic [3:0]        go_q, go_d;
    logic              gwe_q, gwe_d;

    logic              reg_wr;
    logic [2:0]        lane_we;
    logic [23:0]       start_wide;
    logic [23:0]       start_wide_d;
    logic              cmd_wr;
    logic              cmd_fill;
    logic              cmd_abort;
    logic              cmd_pixel;
    logic              fill_empty;
    logic              row_end;
    logic              last_pixel;

    assign reg_wr     = cs_i & we_i;
    // START is kept at ADDR_W bits; the byte view zero-extends it for the register map.
    assign start_wide = 24'(start_q);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_start_lane
            assign lane_we[gi] = reg_wr && (addr_i == 3'(gi));
        end
    endgenerate

    assign cmd_wr     = reg_wr && (addr_i == 3'd7);
    assign cmd_fill   = cmd_wr && din_i[7];
    assign cmd_abort  = cmd_wr && (din_i[7:6] == 2'b01);
    assign cmd_pixel  = cmd_wr && (din_i[7:6] == 2'b00);
    assign fill_empty = (len_q == 10'd0) || (rows_q == 9'd0);
    assign row_end    = (col_q == 10'd1);
    assign last_pixel = row_end && (row_q == 9'd1);

    always_comb begin
        state_d      = state_q;
        start_d      = start_q;
        start_wide_d = start_wide;
        row_base_d   = row_base_q;
        gw_d         = gw_q;
        len_d        = len_q;
        col_d        = col_q;
        rows_d       = rows_q;
        row_d        = row_q;
        color_d      = color_q;
        go_d         = go_q;
        gwe_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                for (int i = 0; i < 3; i++) begin
                    if (lane_we[i]) start_wide_d[i*8 +: 8] = din_i;
                end
                start_d = ADDR_W'(start_wide_d);
                if (reg_wr && addr_i == 3'd3) len_d[7:0]  = din_i;
                if (reg_wr && addr_i == 3'd4) len_d[9:8]  = din_i[1:0];
                if (reg_wr && addr_i == 3'd5) rows_d[7:0] = din_i;
                if (reg_wr && addr_i == 3'd6) rows_d[8]   = din_i[0];

                if (cmd_pixel) begin
                    color_d = din_i[3:0];
                    gwe_d   = 1'b1;
                    gw_d    = start_q;
                    go_d    = din_i[3:0];
                    start_d = start_q + ADDR_W'(1);
                end

                // An empty rectangle still latches the colour but never raises busy.
                if (cmd_fill) begin
                    color_d = din_i[3:0];
                    if (!fill_empty) begin
                        state_d    = S_FILL;
                        gwe_d      = 1'b1;
                        gw_d       = start_q;
                        go_d       = din_i[3:0];
                        row_base_d = start_q;
                        col_d      = len_q;
                        row_d      = rows_q;
                    end
                end
            end

            S_FILL: begin
                // gw_q/col_q/row_q describe the pixel on the port right now.
                if (cmd_abort || last_pixel) begin
                    state_d = S_IDLE;
                end else begin
                    gwe_d = 1'b1;
                    go_d  = color_q;
                    if (row_end) begin
                        row_base_d = row_base_q + ADDR_W'(STRIDE);
                        gw_d       = row_base_q + ADDR_W'(STRIDE);
                        col_d      = len_q;
                        row_d      = row_q - 9'd1;
                    end else begin
                        gw_d  = gw_q + ADDR_W'(1);
                        col_d = col_q - 10'd1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            start_q    <= '0;
            row_base_q <= '0;
            gw_q       <= '0;
            len_q      <= '0;
            col_q      <= '0;
            rows_q     <= '0;
            row_q      <= '0;
            color_q    <= '0;
            go_q       <= '0;
            gwe_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            row_base_q <= row_base_d;
            gw_q       <= gw_d;
            len_q      <= len_d;
            col_q      <= col_d;
            rows_q     <= rows_d;
            row_q      <= row_d;
            color_q    <= color_d;
            go_q       <= go_d;
            gwe_q      <= gwe_d;
        end
    end

    always_comb begin
        dout_o = 8'h00;
        case (addr_i)
            3'd0: dout_o = start_wide[7:0];
            3'd1: dout_o = start_wide[15:8];
            3'd2: dout_o = start_wide[23:16];
            3'd3: dout_o = len_q[7:0];
            3'd4: dout_o = {6'b0, len_q[9:8]};
            3'd5: dout_o = rows_q[7:0];
            3'd6: dout_o = {7'b0, rows_q[8]};
            3'd7: dout_o = {busy_o, 3'b0, color_q};
            default: dout_o = 8'h00;
        endcase
    end

    assign busy_o = (state_q == S_FILL);
    assign gw_o   = gw_q;
    assign go_o   = go_q;
    assign gwe_o  = gwe_q;

endmodule

// File: tb/tb_gfx_fill.sv
// Directed bench for gfx_fill: expected pixel writes are queued as commands are issued
// and a negedge monitor pops and compares every gwe cycle.
module tb_gfx_fill;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        we;
    logic [2:0]  addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        busy;
    logic [17:0] gw;
    logic [3:0]  go;
    logic        gwe;

    typedef struct packed {
        logic [17:0] a;
        logic [3:0]  c;
    } pix_t;

    pix_t exp_q[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   gwe_cnt  = 0;
    int   busy_cnt = 0;

    gfx_fill #(.ADDR_W(18), .STRIDE(640)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .cs_i    (cs),
        .addr_i  (addr),
        .din_i   (din),
        .we_i    (we),
        .dout_o  (dout),
        .busy_o  (busy),
        .gw_o    (gw),
        .go_o    (go),
        .gwe_o   (gwe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        pix_t e;
        if (busy === 1'b1) busy_cnt++;
        if (gwe === 1'b1) begin
            gwe_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_gwe: got gw=%05h go=%h, required no write", gw, go);
            end else begin
                e = exp_q.pop_front();
                if (gw !== e.a || go !== e.c) begin
                    n_bad++;
                    $display("FAIL pixel_write: got gw=%05h go=%h, required gw=%05h go=%h",
                             gw, go, e.a, e.c);
                end else begin
                    $display("pixel gw=%05h go=%h ok", gw, go);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("check %s = %0h ok", name, act);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cs   = 1'b1;
        we   = 1'b1;
        addr = a;
        din  = d;
        @(posedge clk);
        #1;
        cs = 1'b0;
        we = 1'b0;
    endtask

    task automatic rd(input string name, input logic [2:0] a, input logic [7:0] req);
        @(posedge clk);
        #1;
        addr = a;
        #1;
        chk(name, 32'(dout), 32'(req));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int maxc);
        for (int i = 0; i < maxc && busy === 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        chk("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic push(input logic [17:0] a, input logic [3:0] c);
        pix_t p;
        p.a = a;
        p.c = c;
        exp_q.push_back(p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int gb;
        int bb;
        rst  = 1'b1;
        cs   = 1'b0;
        we   = 1'b0;
        addr = 3'd0;
        din  = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gwe", 32'(gwe), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_gw", 32'(gw), 32'd0);
        rst = 1'b0;
        for (int r = 0; r < 8; r++) rd("reset_reg", 3'(r), 8'h00);

        // Two single pixels from START=0x10
        wr(3'd0, 8'h10);
        wr(3'd1, 8'h00);
        wr(3'd2, 8'h00);
        gb = gwe_cnt;
        push(18'h00010, 4'h5);
        push(18'h00011, 4'h5);
        wr(3'd7, 8'h05);
        idle(1);
        wr(3'd7, 8'h05);
        idle(2);
        chk("pixel_count", 32'(gwe_cnt - gb), 32'd2);
        rd("pixel_start_after", 3'd0, 8'h12);
        rd("pixel_color", 3'd7, 8'h05);

        // 3x2 fill at 100
        wr(3'd0, 8'h64);
        wr(3'd1, 8'h00);
        wr(3'd2, 8'h00);
        wr(3'd3, 8'h03);
        wr(3'd4, 8'h00);
        wr(3'd5, 8'h02);
        wr(3'd6, 8'h00);
        gb = gwe_cnt;
        bb = busy_cnt;
        push(18'd100, 4'hA);
        push(18'd101, 4'hA);
        push(18'd102, 4'hA);
        push(18'd740, 4'hA);
        push(18'd741, 4'hA);
        push(18'd742, 4'hA);
        wr(3'd7, 8'h8A);
        addr = 3'd7;
        #1;
        chk("fill_reg7_busy", 32'(dout), 32'h8A);
        wait_idle(20);
        idle(1);
        chk("fill_gwe_cycles", 32'(gwe_cnt - gb), 32'd6);
        chk("fill_busy_cycles", 32'(busy_cnt - bb), 32'd6);
        rd("fill_start_kept", 3'd0, 8'h64);
        rd("fill_reg7_done", 3'd7, 8'h0A);

        // Address wrap at the top of the pixel space
        wr(3'd0, 8'hFF);
        wr(3'd1, 8'hFF);
        wr(3'd2, 8'h03);
        wr(3'd3, 8'h02);
        wr(3'd4, 8'h00);
        wr(3'd5, 8'h01);
        wr(3'd6, 8'h00);
        gb = gwe_cnt;
        push(18'h3FFFF, 4'h1);
        push(18'h00000, 4'h1);
        wr(3'd7, 8'h81);
        wait_idle(20);
        idle(1);
        chk("wrap_gwe_cycles", 32'(gwe_cnt - gb), 32'd2);
        rd("wrap_start_kept", 3'd2, 8'h03);

        // Abort after the 4th pixel, register writes during busy ignored
        wr(3'd0, 8'h00);
        wr(3'd1, 8'h02);
        wr(3'd2, 8'h00);
        wr(3'd3, 8'h0A);
        wr(3'd4, 8'h00);
        wr(3'd5, 8'h01);
        wr(3'd6, 8'h00);
        gb = gwe_cnt;
        push(18'h00200, 4'h3);
        push(18'h00201, 4'h3);
        push(18'h00202, 4'h3);
        push(18'h00203, 4'h3);
        wr(3'd7, 8'h83);
        wr(3'd0, 8'h55);
        wr(3'd3, 8'h77);
        wr(3'd7, 8'h0C);
        for (int i = 0; i < 20 && gwe_cnt < gb + 4; i++) begin
            @(negedge clk);
            #1;
        end
        wr(3'd7, 8'h40);
        idle(3);
        chk("abort_gwe_cycles", 32'(gwe_cnt - gb), 32'd4);
        chk("abort_busy", 32'(busy), 32'd0);
        rd("abort_reg0_kept", 3'd0, 8'h00);
        rd("abort_reg3_kept", 3'd3, 8'h0A);
        rd("abort_reg7", 3'd7, 8'h03);
        wr(3'd7, 8'h40);
        idle(2);
        chk("idle_abort_gwe", 32'(gwe_cnt - gb), 32'd4);
        rd("idle_abort_reg7", 3'd7, 8'h03);

        // Empty fill latches colour only
        wr(3'd3, 8'h00);
        wr(3'd4, 8'h00);
        wr(3'd5, 8'h05);
        wr(3'd6, 8'h00);
        gb = gwe_cnt;
        bb = busy_cnt;
        wr(3'd7, 8'h8F);
        idle(3);
        chk("empty_gwe", 32'(gwe_cnt - gb), 32'd0);
        chk("empty_busy", 32'(busy_cnt - bb), 32'd0);
        rd("empty_reg7", 3'd7, 8'h0F);

        // Reset in the middle of a fill
        wr(3'd0, 8'h00);
        wr(3'd1, 8'h03);
        wr(3'd3, 8'h0A);
        wr(3'd5, 8'h02);
        gb = gwe_cnt;
        push(18'h00300, 4'h2);
        push(18'h00301, 4'h2);
        push(18'h00302, 4'h2);
        wr(3'd7, 8'h82);
        idle(2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("midreset_gwe", 32'(gwe), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_gw", 32'(gw), 32'd0);
        rst = 1'b0;
        idle(2);
        chk("midreset_pixels", 32'(gwe_cnt - gb), 32'd3);
        rd("midreset_reg1", 3'd1, 8'h00);
        rd("midreset_reg7", 3'd7, 8'h00);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
